// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 3;

  typedef enum logic [3:0] {
    sIdle, sPopA, sCapA, sHoldB, sPopB, sCapB, sExec, sWait, sPush
  } statetype;

  localparam logic [DEF_OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [DEF_OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [DEF_OP_W-1:0] OP_CMP = 3'd2;
  localparam logic [DEF_OP_W-1:0] OP_AND = 3'd3;
  localparam logic [DEF_OP_W-1:0] OP_OR  = 3'd4;
  localparam logic [DEF_OP_W-1:0] OP_XOR = 3'd5;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Operand FIFO, result FIFO and ALU handshake bundle; master is the sequencer side.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
);
  logic              src_empty;
  logic              src_pop;
  logic [DATA_W-1:0] src_rd_data;
  logic              dst_full;
  logic              dst_push;
  logic [DATA_W-1:0] dst_wr_data;
  logic              alu_start;
  logic              alu_done;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;

  modport master (
    input  src_empty, src_rd_data, dst_full, alu_done, alu_result,
    output src_pop, dst_push, dst_wr_data, alu_start, alu_op, alu_a, alu_b
  );

  modport slave (
    output src_empty, src_rd_data, dst_full, alu_done, alu_result,
    input  src_pop, dst_push, dst_wr_data, alu_start, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_op_sequencer_timeout_timer.sv
// Counts ALU wait cycles; expired marks the last cycle the ALU is allowed.
module seq_timeout_timer #(
  parameter int ALU_TIMEOUT = 15
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CW'(ALU_TIMEOUT - 1));
endmodule

// File: rtl/alu_op_sequencer.sv
// Drains operand pairs from the source FIFO, runs them through the ALU and
// pushes results to the destination FIFO; counts completions, flags timeouts.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OP_W        = DEF_OP_W,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en,
  input  logic [OP_W-1:0]   opcode,
  alu_op_sequencer_if.master bus,
  output logic              busy,
  output logic [7:0]        op_count,
  output logic              timeout_err
);
  statetype          state;
  logic [DATA_W-1:0] a_reg, b_reg, res_reg;
  logic [OP_W-1:0]   op_reg;
  logic              tmr_expired;

  // Timer only advances while the ALU is still outstanding.
  seq_timeout_timer #(.ALU_TIMEOUT(ALU_TIMEOUT)) u_tmr (
    .clock   (clock),
    .rst     (rst),
    .clear   (state == sExec),
    .enable  ((state == sWait) && !bus.alu_done),
    .expired (tmr_expired)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= sIdle;
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      op_reg      <= '0;
      op_count    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        sIdle:  if (en && !bus.src_empty) begin
                  op_reg <= opcode;
                  state  <= sPopA;
                end
        sPopA:  state <= sCapA;
        sCapA:  begin
                  a_reg <= bus.src_rd_data;
                  state <= bus.src_empty ? sHoldB : sPopB;
                end
        sHoldB: if (!bus.src_empty) state <= sPopB;
        sPopB:  state <= sCapB;
        sCapB:  begin
                  b_reg <= bus.src_rd_data;
                  state <= sExec;
                end
        sExec:  state <= sWait;
        // A done on the final allowed cycle still wins over the timeout.
        sWait:  if (bus.alu_done) begin
                  res_reg <= bus.alu_result;
                  state   <= sPush;
                end else if (tmr_expired) begin
                  timeout_err <= 1'b1;
                  state       <= sIdle;
                end
        sPush:  if (!bus.dst_full) begin
                  op_count <= op_count + 8'd1;
                  state    <= sIdle;
                end
        default: state <= sIdle;
      endcase
    end
  end

  assign bus.src_pop     = (state == sPopA) || (state == sPopB);
  assign bus.alu_start   = (state == sExec);
  assign bus.dst_push    = (state == sPush) && !bus.dst_full;
  assign bus.dst_wr_data = res_reg;
  assign bus.alu_op      = op_reg;
  assign bus.alu_a       = a_reg;
  assign bus.alu_b       = b_reg;
  assign busy            = (state != sIdle);
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + randomized bench: FIFO, ALU and result-sink models around the sequencer.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int DW = 8;
  localparam int OW = 3;

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic          en    = 1'b0;
  logic [OW-1:0] opcode = '0;
  logic          busy;
  logic [7:0]    op_count;
  logic          timeout_err;

  alu_op_sequencer_if #(.DATA_W(DW), .OP_W(OW)) bus ();

  alu_op_sequencer #(.DATA_W(DW), .OP_W(OW), .ALU_TIMEOUT(15)) dut (
    .clock       (clock),
    .rst         (rst),
    .en          (en),
    .opcode      (opcode),
    .bus         (bus),
    .busy        (busy),
    .op_count    (op_count),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          ri = 0;
  int          pop_cnt = 0;
  int          alu_lat = 1;
  int          alu_cnt = 0;
  logic [7:0]  ca, cb;
  logic [2:0]  co;

  // Result FIFO: records every accepted push.
  always @(negedge clock)
    if (bus.dst_push) got_q.push_back(bus.dst_wr_data);

  function automatic logic [7:0] alu_f(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_CMP:  return (a < b) ? 8'd1 : 8'd0;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] d);
    fifo_q.push_back(d);
    bus.src_empty = 1'b0;
  endtask

  // Advance one clock; operand FIFO and ALU react just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    if (bus.src_pop) begin
      pop_cnt++;
      if (fifo_q.size() > 0) bus.src_rd_data = fifo_q.pop_front();
    end
    bus.src_empty = (fifo_q.size() == 0);
    bus.alu_done = 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        bus.alu_done   = 1'b1;
        bus.alu_result = alu_f(co, ca, cb);
      end
    end
    if (bus.alu_start) begin
      alu_cnt = alu_lat;
      ca = bus.alu_a; cb = bus.alu_b; co = bus.alu_op;
    end
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (busy && n < max) begin step(); n++; end
    check(tag, busy, 0);
  endtask

  task automatic check_results();
    check("n_results", got_q.size(), exp_q.size());
    while (ri < exp_q.size() && ri < got_q.size()) begin
      check($sformatf("result[%0d]", ri), got_q[ri], exp_q[ri]);
      ri++;
    end
  endtask

  initial begin
    int p0, nres;
    logic [7:0] c0;
    logic [7:0] opa[256], opb[256];
    logic [2:0] opc[256];
    int base, issued, drop_cnt, n;
    bit mid_done;

    bus.src_empty = 1'b1; bus.src_rd_data = '0; bus.dst_full = 1'b0;
    bus.alu_done = 1'b0;  bus.alu_result = '0;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_src_pop", bus.src_pop, 0);
    check("rst_dst_push", bus.dst_push, 0);
    check("rst_alu_start", bus.alu_start, 0);
    check("rst_wr_data", bus.dst_wr_data, 0);
    check("rst_alu_ab", {bus.alu_a, bus.alu_b}, 0);
    step(); step();
    rst = 1'b0;
    step();

    // 1: minimum latency ADD
    put(8'h12); put(8'h34); opcode = OP_ADD; alu_lat = 1; en = 1'b1;
    exp_q.push_back(8'h46);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin en = 1'b0; check("t1_pop_a", bus.src_pop, 1); end
      if (k == 5) check("t1_start", bus.alu_start, 1);
      if (k == 6) begin
        check("t1_alu_a", bus.alu_a, 8'h12);
        check("t1_alu_b", bus.alu_b, 8'h34);
        check("t1_alu_op", bus.alu_op, OP_ADD);
      end
      if (k == 7) begin
        check("t1_push", bus.dst_push, 1);
        check("t1_wr_data", bus.dst_wr_data, 8'h46);
      end
      if (k == 8) begin
        check("t1_idle", busy, 0);
        check("t1_op_count", op_count, 1);
      end
    end
    check_results();

    // 2: second operand arrives late
    put(8'h05); opcode = OP_SUB; en = 1'b1; p0 = pop_cnt;
    exp_q.push_back(8'h02);
    step(); en = 1'b0;
    repeat (10) step();
    check("t2_holding", busy, 1);
    check("t2_pop_during_hold", bus.src_pop, 0);
    check("t2_one_pop", pop_cnt - p0, 1);
    put(8'h03);
    wait_idle(30, "t2_idle");
    check("t2_two_pops", pop_cnt - p0, 2);
    check("t2_alu_a", bus.alu_a, 8'h05);
    check("t2_alu_b", bus.alu_b, 8'h03);
    check_results();

    // 3: result FIFO full for 5 cycles
    put(8'h20); put(8'h90); opcode = OP_CMP; alu_lat = 1; bus.dst_full = 1'b1; en = 1'b1;
    exp_q.push_back(8'h01); c0 = op_count;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 1) en = 1'b0;
      if (k >= 7 && k <= 11) begin
        check($sformatf("t3_held_%0d", k), {busy, bus.dst_push}, 2'b10);
        check("t3_res_stable", bus.dst_wr_data, 8'h01);
      end
      if (k == 12) begin
        bus.dst_full = 1'b0; #1;
        check("t3_push", bus.dst_push, 1);
        check("t3_wr_data", bus.dst_wr_data, 8'h01);
      end
      if (k == 13) check("t3_idle", busy, 0);
    end
    check("t3_op_count", op_count, c0 + 8'd1);
    check_results();

    // 4: ALU never answers, then answers on the last allowed cycle
    put(8'h09); put(8'h04); opcode = OP_XOR; alu_lat = 0; en = 1'b1;
    c0 = op_count; nres = got_q.size();
    for (int k = 1; k <= 21; k++) begin
      step();
      if (k == 1) en = 1'b0;
      if (k == 20) check("t4_still_wait", {busy, timeout_err}, 2'b10);
      if (k == 21) check("t4_timed_out", {busy, timeout_err}, 2'b01);
    end
    check("t4_op_count", op_count, c0);
    check("t4_no_push", got_q.size(), nres);
    put(8'hF0); put(8'h0F); opcode = OP_OR; alu_lat = 15; en = 1'b1;
    exp_q.push_back(8'hFF);
    step(); en = 1'b0;
    wait_idle(40, "t4b_idle");
    check("t4b_sticky", timeout_err, 1);
    check("t4b_op_count", op_count, c0 + 8'd1);
    check_results();

    // 5: asynchronous reset mid-WAIT
    put(8'h01); put(8'h02); opcode = OP_ADD; alu_lat = 0; en = 1'b1;
    step(); en = 1'b0;
    repeat (9) step();
    check("t5_in_wait", busy, 1);
    nres = got_q.size();
    #2 rst = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_start", bus.alu_start, 0);
    check("t5_pop", bus.src_pop, 0);
    check("t5_push", bus.dst_push, 0);
    check("t5_op_count", op_count, 0);
    check("t5_timeout", timeout_err, 0);
    check("t5_wr_data", bus.dst_wr_data, 0);
    step(); step();
    #2 rst = 1'b0;
    repeat (20) step();
    check("t5_stays_idle", busy, 0);
    check("t5_no_push", got_q.size(), nres);

    // 6: 256 back-to-back random operations, en dropped in CAP_B of op 100
    for (int i = 0; i < 256; i++) begin
      opa[i] = 8'($urandom); opb[i] = 8'($urandom); opc[i] = 3'($urandom_range(0, 5));
      put(opa[i]); put(opb[i]);
      exp_q.push_back(alu_f(opc[i], opa[i], opb[i]));
    end
    base = got_q.size(); issued = 0; drop_cnt = 0; n = 0; mid_done = 0;
    en = 1'b1;
    while (got_q.size() < base + 256 && n < 20000) begin
      if (!busy && issued < 256) begin
        if (!en) begin
          check("t6_en_drop_completed", got_q.size(), base + 101);
          en = 1'b1;
        end
        opcode = opc[issued];
        issued++;
        if (issued == 101) drop_cnt = 4;
      end
      alu_lat = $urandom_range(1, 14);
      bus.dst_full = ($urandom_range(0, 3) == 0);
      step(); n++;
      if (drop_cnt > 0) begin
        drop_cnt--;
        if (drop_cnt == 0) en = 1'b0;
      end
      if (!mid_done && got_q.size() == base + 255) begin
        check("t6_op_count_255", op_count, 8'd255);
        mid_done = 1;
      end
    end
    bus.dst_full = 1'b0; en = 1'b0;
    check("t6_all_pushed", got_q.size(), base + 256);
    check("t6_op_count_wrap", op_count, 0);
    check_results();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
